// File: rtl/ringosc_meas_ctrl.sv
// Measurement sequencer for the ring oscillator: clears the divider, lets the ring settle,
// then counts synchronised rising edges of one divider tap over a programmed window.
module ringosc_meas_ctrl #(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int CLEAR_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window,
  input  logic             osc_tap,
  output logic             ring_ena,
  output logic             div_rst_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overflow
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] SETTLE  = 3'd2;
  localparam logic [2:0] MEASURE = 3'd3;
  localparam logic [2:0] STOP    = 3'd4;

  localparam int PH_W  = $clog2(CLEAR_CYCLES + SETTLE_CYCLES + 1);
  localparam int TMR_W = (WIN_W > PH_W) ? WIN_W : PH_W;

  logic [2:0]             state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [WIN_W-1:0]       win_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic                   accept;

  assign rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign accept = (state_q == IDLE) && start;

  // One shared phase timer; it restarts from zero on every state change.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TMR_W'(1);
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        if (tmr_q == TMR_W'(CLEAR_CYCLES - 1)) begin
          state_d = SETTLE;
          tmr_d   = '0;
        end
      end
      SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          state_d = (win_q == '0) ? STOP : MEASURE;
          tmr_d   = '0;
        end
      end
      MEASURE: begin
        if (tmr_q == TMR_W'(win_q) - TMR_W'(1)) begin
          state_d = STOP;
          tmr_d   = '0;
        end
      end
      STOP: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      tmr_d   = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = overflow;
    if (accept) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if ((state_q == MEASURE) && rise) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs decode the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      sync_q       <= '0;
      hist_q       <= 1'b0;
      ring_ena     <= 1'b0;
      div_rst_n    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      overflow  <= ovf_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], osc_tap};
      hist_q    <= sync_q[SYNC_STAGES-1];
      if (accept) win_q <= window;
      ring_ena  <= (state_d == SETTLE) || (state_d == MEASURE);
      div_rst_n <= (state_d != CLEAR);
      busy      <= (state_d != IDLE);
      done      <= (state_d == STOP);
      if (state_d == STOP) begin
        result       <= cnt_d;
        result_valid <= 1'b1;
      end else if (accept) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule
